sigmoid_pwl_pipe: RTL and testbench



---
 rtl/sigmoid_pkg.sv | 41 ++++
 rtl/sigmoid_pwl_core.sv | 79 +++++++
 rtl/sigmoid_pwl_pipe.sv | 75 +++++++
 tb/tb_sigmoid_pwl_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_pkg.sv
// sigmoid_pkg: definitions shared by the sigmoid/tanh pipeline.
//   - Q-format width helpers (input width IW+FW, output width FW+2)
//   - HALF / ONE constants as functions of FW
//   - mode_e: MODE_SIGMOID / MODE_TANH
//   - stage_t: payload carried between pipeline stages. The i and fh fields
//     are sized to PAY_W so that one struct serves every legal IW/FW.
//     IW+FW must not exceed PAY_W. fh holds the fraction f after stage 1
//     and the shaped value h after stage 2.
package sigmoid_pkg;

  localparam int PAY_W = 32;

  typedef enum logic {
    MODE_SIGMOID = 1'b0,
    MODE_TANH    = 1'b1
  } mode_e;

  typedef struct packed {
    logic             neg;
    mode_e            mode;
    logic [PAY_W-1:0] i;
    logic [PAY_W-1:0] fh;
  } stage_t;

  function automatic int in_width(input int iw, input int fw);
    return iw + fw;
  endfunction

  function automatic int out_width(input int fw);
    return fw + 2;
  endfunction

  function automatic int unsigned half_val(input int fw);
    return 32'd1 << (fw - 1);
  endfunction

  function automatic int unsigned one_val(input int fw);
    return 32'd1 << fw;
  endfunction

endpackage

// File: rtl/sigmoid_pwl_core.sv
// sigmoid_pwl_core: purely combinational math for the three pipeline stages.
// Each stage is independent, so the wrapper feeds each one from a different
// pipeline register.
//   x, mode -> mag_out : stage 1, sign split and magnitude
//   shp_in  -> shp_out : stage 2, power-of-two shape h
//   sel_in  -> y       : stage 3, final sigmoid or tanh value
// Optional macro TANH_MODE_EN: mode=MODE_TANH pre-doubles x, with
// saturation, and maps y to 2y-ONE. Without the macro, mode is carried
// along but has no effect.
module sigmoid_pwl_core
  import sigmoid_pkg::*;
#(
  parameter  int IW = 8,
  parameter  int FW = 8,
  localparam int W  = in_width(IW, FW),
  localparam int OW = out_width(FW)
) (
  input  logic [W-1:0]  x,
  input  logic          mode,
  output stage_t        mag_out,
  input  stage_t        shp_in,
  output stage_t        shp_out,
  input  stage_t        sel_in,
  output logic [OW-1:0] y
);

  localparam logic [PAY_W-1:0] HALF = PAY_W'(half_val(FW));
  localparam logic [PAY_W-1:0] ONE  = PAY_W'(one_val(FW));

  // Stage 1: magnitude. The W-bit negate of -2^(W-1) gives 2^(W-1).
  // Read as unsigned, this value is the correct magnitude.
  logic [W-1:0] xd;
  logic [W-1:0] m;

  always_comb begin
    xd = x;
`ifdef TANH_MODE_EN
    if (mode_e'(mode) == MODE_TANH) begin
      // A doubling overflows exactly when the top two bits differ.
      if (x[W-1] != x[W-2])
        xd = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      else
        xd = {x[W-2:0], 1'b0};
    end
`endif
    m            = xd[W-1] ? -xd : xd;
    mag_out.neg  = xd[W-1];
    mag_out.mode = mode_e'(mode);
    mag_out.i    = PAY_W'(m[W-1:FW]);
    mag_out.fh   = PAY_W'(m[FW-1:0]);
  end

  // Stage 2: shape. f < 2^FW, so f>>2 < HALF, and the subtraction cannot wrap.
  always_comb begin
    shp_out = shp_in;
    if (shp_in.i >= PAY_W'(FW + 1))
      shp_out.fh = '0;
    else
      shp_out.fh = (HALF - (shp_in.fh >> 2)) >> shp_in.i;
  end

  // Stage 3: select. y_sig spans 0..ONE, and this range fits in OW bits.
  logic [OW-1:0] y_sig;

  always_comb begin
    y_sig = OW'(sel_in.neg ? sel_in.fh : (ONE - sel_in.fh));
    y     = y_sig;
`ifdef TANH_MODE_EN
    if (sel_in.mode == MODE_TANH)
      y = (y_sig << 1) - OW'(ONE);
`endif
  end

  // The magnitude index is dead after stage 2. The mode field is dead
  // when tanh support is not built.
  logic unused_sel;
  assign unused_sel = ^{sel_in.i, sel_in.mode};

endmodule

// File: rtl/sigmoid_pwl_pipe.sv
// sigmoid_pwl_pipe: three-stage pipelined piecewise-linear sigmoid
// approximation on signed Q(IW.FW) samples. The result is Q(2.FW).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ena                block enable; when low, the pipeline freezes
//   in_valid/in_ready  input stream handshake; in_data is Q(IW.FW)
//   mode               0 = sigmoid, 1 = tanh (only with TANH_MODE_EN)
//   out_valid/out_ready output stream handshake; out_data is OW = FW+2 bits
// Optional macro TANH_MODE_EN enables the tanh mode.
//
// Handshake: a word moves on any cycle where valid and ready are both high.
// The stall condition is (held output valid) & ~out_ready. The
// stall is global: in_ready = ena & ~stall, and every stage register moves
// only on in_ready. So out_data/out_valid stay stable during a stall. While
// ena is low, out_valid is masked, so a frozen output is never consumed twice.
module sigmoid_pwl_pipe
  import sigmoid_pkg::*;
#(
  parameter  int IW = 8,
  parameter  int FW = 8,
  localparam int OW = out_width(FW)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IW+FW-1:0]   in_data,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OW-1:0]      out_data
);

  logic          v1, v2, ov_q;
  stage_t        s1_q, s2_q;
  stage_t        s1_next, s2_next;
  logic [OW-1:0] y_next;
  logic          stall;

  assign stall     = ov_q & ~out_ready;
  assign in_ready  = ena & ~stall;
  assign out_valid = ov_q & ena;

  sigmoid_pwl_core #(.IW(IW), .FW(FW)) u_core (
    .x       (in_data),
    .mode    (mode),
    .mag_out (s1_next),
    .shp_in  (s1_q),
    .shp_out (s2_next),
    .sel_in  (s2_q),
    .y       (y_next)
  );

  // Data registers load only behind a valid word. Bubbles leave the old
  // contents in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      ov_q     <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      out_data <= '0;
    end else if (in_ready) begin
      v1   <= in_valid;
      v2   <= v1;
      ov_q <= v2;
      if (in_valid) s1_q     <= s1_next;
      if (v1)       s2_q     <= s2_next;
      if (v2)       out_data <= y_next;
    end
  end

endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// tb_sigmoid_pwl_pipe: self-checking bench for sigmoid_pwl_pipe (IW=8, FW=8).
// The expected values come from a plain integer model of the approximation.
// Build with TANH_MODE_EN to also exercise tanh mode.
module tb_sigmoid_pwl_pipe;

  localparam int IW   = 8;
  localparam int FW   = 8;
  localparam int W    = IW + FW;
  localparam int OW   = FW + 2;
  localparam int ONE  = 1 << FW;
  localparam int HALF = 1 << (FW - 1);

  logic          clk = 1'b0;
  logic          rst_n, ena, in_valid, in_ready, mode;
  logic          out_valid, out_ready;
  logic [W-1:0]  in_data;
  logic [OW-1:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit lat_chk  = 1'b0;
  bit done     = 1'b0;

  logic [OW-1:0] exp_q[$];
  int            acc_q[$];

  sigmoid_pwl_pipe #(.IW(IW), .FW(FW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [OW-1:0] model(input logic [W-1:0] x, input logic m);
    int xi, mag, ip, fp, h, y;
    xi = $signed(x);
`ifdef TANH_MODE_EN
    if (m) begin
      xi = 2 * xi;
      if (xi > (1 << (W-1)) - 1) xi = (1 << (W-1)) - 1;
      if (xi < -(1 << (W-1)))    xi = -(1 << (W-1));
    end
`endif
    mag = (xi < 0) ? -xi : xi;
    ip  = mag / ONE;
    fp  = mag % ONE;
    h   = (ip > FW) ? 0 : (HALF - fp / 4) / (1 << ip);
    y   = (xi < 0) ? h : ONE - h;
`ifdef TANH_MODE_EN
    if (m) y = 2 * y - ONE;
`else
    if (m) y = y;
`endif
    return OW'(y);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  // Both handshakes are sampled on the falling edge. At that point, the signals
  // hold the values that transfer at the next rising edge.
  always @(negedge clk) begin
    logic [OW-1:0] e;
    int a;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, mode));
        acc_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        check("out_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("out_data", 32'(out_data), 32'(e));
          if (lat_chk) check("latency", 32'(cyc - a), 32'd3);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] x, input logic m);
    int n = 0;
    in_data  = x;
    mode     = m;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic stall_window();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_first_out_seen", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      if (exp_q.size() != 0) check("stall_out_held", 32'(out_data), 32'(exp_q[0]));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
  endtask

  task automatic ena_window();
    repeat (2) @(posedge clk);
    #1 ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ena_low_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 ena = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] edge_vals [8];

  initial begin
    edge_vals = '{16'h7FFF, 16'h8000, 16'h8001, 16'h0000,
                  16'hFFFF, 16'h0800, 16'h0900, 16'hF700};
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_data = '0;
    mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back directed samples and extremes, with no stall.
    lat_chk = 1'b1;
    send(16'h0000, 1'b0); send(16'h0080, 1'b0);
    send(16'h0100, 1'b0); send(16'hFF00, 1'b0);
    send(16'h7FFF, 1'b0); send(16'h8000, 1'b0);
`ifdef TANH_MODE_EN
    send(16'h0080, 1'b1); send(16'hFF80, 1'b1); send(16'h0000, 1'b1);
`endif
    drain();
    lat_chk = 1'b0;

    // Output stall for 5 cycles after the first result.
    fork
      begin
        send(16'h0100, 1'b0); send(16'hFF80, 1'b0);
        send(16'h0040, 1'b0); send(16'hFE00, 1'b0);
      end
      stall_window();
    join
    drain();

    // Enable dropped for 3 cycles mid-stream.
    fork
      begin
        send(16'h0180, 1'b0); send(16'hFF40, 1'b0);
        send(16'h0300, 1'b0); send(16'hFC80, 1'b0);
      end
      ena_window();
    join
    drain();

    // Reset pulsed between clock edges while samples are in flight.
    in_valid = 1'b1; in_data = 16'h0100; mode = 1'b0;
    @(posedge clk);
    #1 in_data = 16'h0080;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_data", 32'(out_data), 32'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send(16'h0200, 1'b0); send(16'hFFC0, 1'b1);
    drain();
    lat_chk = 1'b0;

    // Randomized traffic with random back-pressure, enable and mode.
    fork
      begin
        for (int k = 0; k < 150; k++) begin
          logic [W-1:0] x;
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          if ($urandom_range(0, 5) == 0) x = edge_vals[$urandom_range(0, 7)];
          else                           x = W'($urandom);
          send(x, 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          ena       = ($urandom_range(0, 7) != 0);
        end
        out_ready = 1'b1;
        ena       = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
